// File: rtl/decode_hazard_ctrl.sv
// Decode-stage sequencing controller: shadows in-flight destination registers,
// stalls decode on RAW hazards, squashes on taken branches, holds after reset.
module decode_hazard_ctrl #(
    parameter int unsigned RST_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        mem_br_taken,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    output logic        pc_write_en,
    output logic        if_id_write_en,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        hazard,
    output logic        sb_error,
    output logic [15:0] stall_count
);

    typedef enum logic [0:0] {
        HOLD,
        RUN
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] hold_cnt;

    logic       ex_valid;
    logic       mem_valid;
    logic       wb_valid;
    logic [4:0] ex_rd;
    logic [4:0] mem_rd;
    logic [4:0] wb_slot_rd;

    logic       rs1_hit;
    logic       rs2_hit;
    logic       raw;
    logic       issue;
    logic       stall;
    logic       wb_live;
    logic       wb_mismatch;

    // x0 is excluded on both sides: slots never hold rd 0, and reads of x0 never match.
    always_comb begin
        rs1_hit = id_use_rs1 && (id_rs1 != '0) &&
                  ((ex_valid  && (ex_rd      == id_rs1)) ||
                   (mem_valid && (mem_rd     == id_rs1)) ||
                   (wb_valid  && (wb_slot_rd == id_rs1)));
        rs2_hit = id_use_rs2 && (id_rs2 != '0) &&
                  ((ex_valid  && (ex_rd      == id_rs2)) ||
                   (mem_valid && (mem_rd     == id_rs2)) ||
                   (wb_valid  && (wb_slot_rd == id_rs2)));
        raw     = id_valid && (rs1_hit || rs2_hit);
    end

    always_comb begin
        wb_live     = wb_regwrite && (wb_rd != '0);
        wb_mismatch = (wb_valid != wb_live) ||
                      (wb_valid && wb_live && (wb_slot_rd != wb_rd));
    end

    always_comb begin
        state_next     = state;
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        if_id_flush    = 1'b1;
        id_ex_bubble   = 1'b1;
        hazard         = 1'b0;
        issue          = 1'b0;
        stall          = 1'b0;
        case (state)
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                hazard         = raw;
                pc_write_en    = 1'b1;
                if_id_write_en = 1'b1;
                if_id_flush    = 1'b0;
                id_ex_bubble   = 1'b0;
                // A taken branch overrides any stall: the stalled instruction is squashed anyway.
                if (mem_br_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (raw) begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_bubble   = 1'b1;
                    stall          = 1'b1;
                end
                issue = id_valid && !raw && !mem_br_taken;
            end
            default: state_next = HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HOLD;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= 4'(RST_HOLD - 1);
        end else if ((state == HOLD) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            mem_valid  <= 1'b0;
            wb_valid   <= 1'b0;
            ex_rd      <= '0;
            mem_rd     <= '0;
            wb_slot_rd <= '0;
        end else if (state == RUN) begin
            wb_valid   <= mem_valid;
            wb_slot_rd <= mem_rd;
            mem_valid  <= ex_valid && !mem_br_taken;
            mem_rd     <= ex_rd;
            ex_valid   <= issue && id_regwrite && (id_rd != '0);
            ex_rd      <= id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_error <= 1'b0;
        end else if ((state == RUN) && wb_mismatch) begin
            sb_error <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Scoreboard bench for decode_hazard_ctrl: directed ID/MEM/WB vectors push
// hand-computed expectations; a negedge monitor pops and compares them.
module tb_decode_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        mem_br_taken;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic        pc_write_en;
    logic        if_id_write_en;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        hazard;
    logic        sb_error;
    logic [15:0] stall_count;

    decode_hazard_ctrl #(.RST_HOLD(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .id_rd          (id_rd),
        .id_regwrite    (id_regwrite),
        .mem_br_taken   (mem_br_taken),
        .wb_regwrite    (wb_regwrite),
        .wb_rd          (wb_rd),
        .pc_write_en    (pc_write_en),
        .if_id_write_en (if_id_write_en),
        .if_id_flush    (if_id_flush),
        .id_ex_bubble   (id_ex_bubble),
        .hazard         (hazard),
        .sb_error       (sb_error),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int when;
        int sig;
        int val;
    } exp_t;

    exp_t       sbq[$];
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    bit         quiet = 0;
    bit         force_en = 0;
    logic [4:0] force_rd = '0;
    logic [4:0] wb_at [int];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sig_name(input int s);
        case (s)
            0: return "pc_write_en";
            1: return "if_id_write_en";
            2: return "if_id_flush";
            3: return "id_ex_bubble";
            4: return "hazard";
            5: return "sb_error";
            default: return "stall_count";
        endcase
    endfunction

    function automatic int sig_val(input int s);
        case (s)
            0: return int'(pc_write_en);
            1: return int'(if_id_write_en);
            2: return int'(if_id_flush);
            3: return int'(id_ex_bubble);
            4: return int'(hazard);
            5: return int'(sb_error);
            default: return int'(stall_count);
        endcase
    endfunction

    exp_t e;
    int   act;
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].when <= cyc) begin
            e = sbq.pop_front();
            act = sig_val(e.sig);
            n_total++;
            if (e.when != cyc)
                $display("FAIL %s cyc %0d: expectation not sampled (now cyc %0d)", sig_name(e.sig), e.when, cyc);
            else if (act == e.val)
                n_pass++;
            else
                $display("FAIL %s cyc %0d: got %0h expected %0h", sig_name(e.sig), cyc, act, e.val);
        end
    end

    task automatic push(input int sig, input int val);
        if (val >= 0) sbq.push_back('{cyc, sig, val});
    endtask

    task automatic chk(input int sig, input int val);
        push(sig, val);
    endtask

    // Apply one cycle of ID/MEM inputs; ep also covers if_id_write_en. -1 = unchecked.
    task automatic vec(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic br,
                       input int eh, input int ep, input int ef, input int eb);
        id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
        id_rd = rd; id_regwrite = rw; mem_br_taken = br;
        // A taken branch kills whatever is in EX; it would have written back two cycles later.
        if (br && wb_at.exists(cyc + 2)) wb_at.delete(cyc + 2);
        if (force_en) begin
            wb_regwrite = 1'b1; wb_rd = force_rd; force_en = 0;
        end else if (wb_at.exists(cyc)) begin
            wb_regwrite = 1'b1; wb_rd = wb_at[cyc];
        end else begin
            wb_regwrite = 1'b0; wb_rd = 5'd3;
        end
        if (wb_at.exists(cyc)) wb_at.delete(cyc);
        if (v && ep == 1 && eh != 1 && !br && rw && rd != 0) wb_at[cyc + 3] = rd;
        if (!quiet) begin
            push(0, ep); push(1, ep); push(2, ef); push(3, eb); push(4, eh);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic chain_step();
        for (int i = 0; i < 3; i++) vec(1, 5, 1, 0, 0, 5, 1, 0, 1, 0, 0, 1);
        vec(1, 5, 1, 0, 0, 5, 1, 0, 0, 1, 0, 0);
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_regwrite = 0; mem_br_taken = 0; wb_regwrite = 0; wb_rd = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state while rst is held
        chk(5, 0); chk(6, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Release: cycles 0-3 held, cycle 4 runs
        rst = 1'b0;
        for (int i = 0; i < 4; i++) vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        // addi x5 then add x6,x5,x5: three stalls, issue on the fourth
        vec(1, 0, 1, 0, 0, 5, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) vec(1, 5, 1, 5, 1, 6, 1, 0, 1, 0, 0, 1);
        chk(6, 3);
        vec(1, 5, 1, 5, 1, 6, 1, 0, 0, 1, 0, 0);
        idle(3);

        // Distance 2 (gap is an invalid slot whose fields would match): two stalls
        vec(1, 0, 1, 0, 0, 10, 1, 0, 0, 1, 0, 0);
        vec(0, 10, 1, 10, 1, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) vec(1, 0, 0, 10, 1, 0, 0, 0, 1, 0, 0, 1);
        chk(6, 5);
        vec(1, 0, 0, 10, 1, 0, 0, 0, 0, 1, 0, 0);

        // Distance 3: one stall
        vec(1, 0, 1, 0, 0, 11, 1, 0, 0, 1, 0, 0);
        idle(2);
        vec(1, 11, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        vec(1, 11, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk(6, 6);

        // Unused source fields never stall; distance 4 is clear
        vec(1, 0, 1, 0, 0, 12, 1, 0, 0, 1, 0, 0);
        vec(1, 12, 0, 12, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        vec(1, 12, 1, 12, 1, 0, 0, 0, 0, 1, 0, 0);

        // x0 producer / x0 consumer
        vec(1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        vec(1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0);
        idle(3);
        chk(5, 0); chk(6, 6);

        // Consumer of x7 stalled, then branch taken while x7 sits in s_mem
        vec(1, 0, 1, 0, 0, 7, 1, 0, 0, 1, 0, 0);
        vec(1, 7, 1, 0, 0, 8, 1, 0, 1, 0, 0, 1);
        vec(1, 7, 1, 0, 0, 8, 1, 1, -1, 1, 1, 1);
        chk(6, 7);
        vec(1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);

        // Branch kills a valid s_ex entry before it can reach s_mem
        vec(1, 0, 1, 0, 0, 13, 1, 0, 0, 1, 0, 0);
        vec(1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1);
        vec(1, 13, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(3);
        chk(5, 0); chk(6, 7);

        // WB write to x10 while s_wb holds x9: sticky error
        vec(1, 0, 1, 0, 0, 9, 1, 0, 0, 1, 0, 0);
        idle(2);
        force_en = 1; force_rd = 5'd10;
        chk(5, 0);
        idle(1);
        chk(5, 1);
        idle(1);
        chk(5, 1);
        idle(1);

        // Reset mid-stall: slots cleared, counters cleared
        vec(1, 0, 1, 0, 0, 5, 1, 0, 0, 1, 0, 0);
        vec(1, 5, 1, 0, 0, 6, 1, 0, 1, 0, 0, 1);
        rst = 1'b1;
        wb_at.delete();
        vec(1, 5, 1, 0, 0, 6, 1, 0, -1, -1, -1, -1);
        rst = 1'b0;
        chk(5, 0); chk(6, 0);
        for (int i = 0; i < 4; i++) vec(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1, 1);
        vec(1, 5, 1, 0, 0, 6, 1, 0, 0, 1, 0, 0);

        // Saturation: chained add x5,x5,x5 gives 3 stalls per step
        vec(1, 5, 1, 0, 0, 5, 1, 0, 0, 1, 0, 0);
        quiet = 1;
        for (int i = 0; i < 100; i++) chain_step();
        chk(6, 300);
        for (int i = 100; i < 21845; i++) chain_step();
        chk(6, 16'hFFFF);
        quiet = 0;
        chain_step();
        chk(6, 16'hFFFF); chk(5, 0);
        idle(1);

        @(negedge clk);
        @(negedge clk);
        if (sbq.size() != 0) begin
            $display("FAIL scoreboard: %0d expectations never sampled", sbq.size());
            n_total += sbq.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
